// File: rtl/cache_set.sv
// cache_set: one index of an N-way set-associative cache.
// Contents: two combinational lookup ports, a byte-enabled line write port,
// tree pseudo-LRU victim selection, and a flush engine that streams dirty
// lines out over a valid/ready handshake.
// Optional build macro: CACHE_SET_STATS_EN adds statStrobe/hitCount/missCount.
module cache_set #(
    parameter int NUM_WAYS         = 4,
    parameter int CACHE_LINE_WIDTH = 6,
    parameter int TAG_WIDTH        = 20,
    parameter int ADDR_WIDTH       = 32,
    localparam int WAY_W           = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_WIDTH-1:0]       rdAddr,
    output logic                        rdHit,
    output logic [WAY_W-1:0]            rdWay,
    output logic [31:0]                 rdData,
    input  logic [ADDR_WIDTH-1:0]       rd2Addr,
    output logic                        rd2Hit,
    output logic [WAY_W-1:0]            rd2Way,
    output logic [31:0]                 rd2Data,
    input  logic                        touch,
    input  logic [WAY_W-1:0]            touchWay,
    input  logic                        write,
    input  logic [WAY_W-1:0]            wrWay,
    input  logic [CACHE_LINE_WIDTH-1:0] wrOff,
    input  logic [TAG_WIDTH-1:0]        wrTag,
    input  logic                        wrValid,
    input  logic                        wrDirty,
    input  logic [31:0]                 wrData,
    input  logic [3:0]                  wrByteEnable,
    output logic [WAY_W-1:0]            victimWay,
    output logic                        victimValid,
    output logic                        victimDirty,
    output logic [TAG_WIDTH-1:0]        victimTag,
    input  logic                        flushReq,
    input  logic                        flushInv,
    output logic                        flushBusy,
    output logic                        flushDone,
    output logic                        wbValid,
    input  logic                        wbReady,
    output logic [WAY_W-1:0]            wbWay,
    output logic [TAG_WIDTH-1:0]        wbTag,
    output logic [CACHE_LINE_WIDTH-1:0] wbOff,
`ifdef CACHE_SET_STATS_EN
    input  logic                        statStrobe,
    output logic [31:0]                 hitCount,
    output logic [31:0]                 missCount,
`endif
    output logic [31:0]                 wbData
);

    localparam int LEVELS = $clog2(NUM_WAYS);
    localparam int OFF_W  = CACHE_LINE_WIDTH - 2;
    localparam int WORDS  = 1 << OFF_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Line storage; the PLRU vector has one spare top bit so a WAY_W-bit
    // node index always lands inside it (node NUM_WAYS-1 is never used).
    logic [TAG_WIDTH-1:0] tag_q  [NUM_WAYS];
    logic [TAG_WIDTH-1:0] tag_d  [NUM_WAYS];
    logic [31:0]          data_q [NUM_WAYS][WORDS];
    logic [31:0]          data_d [NUM_WAYS][WORDS];
    logic [NUM_WAYS-1:0]  valid_q, valid_d, dirty_q, dirty_d;
    logic [NUM_WAYS-1:0]  plru_q, plru_d;

    state_e               state_q, state_d;
    logic [WAY_W-1:0]     way_q, way_d;
    logic [OFF_W-1:0]     cnt_q, cnt_d;
    logic                 inv_q, inv_d;

    logic                 busy_s, wb_fire_s, last_way_s, last_word_s;
    logic [WAY_W-1:0]     plru_leaf_s;
    logic                 unused_ok_s;

    assign busy_s      = (state_q != ST_IDLE);
    assign wb_fire_s   = (state_q == ST_WB) && wbReady;
    assign last_way_s  = (way_q == WAY_W'(NUM_WAYS - 1));
    assign last_word_s = (cnt_q == OFF_W'(WORDS - 1));
    assign unused_ok_s = ^{rdAddr, rd2Addr, wrOff[1:0], plru_q[NUM_WAYS-1]};

    // Two independent tag-compare lookups on registered state
    always_comb begin
        rdHit   = 1'b0;
        rdWay   = '0;
        rdData  = 32'h0;
        rd2Hit  = 1'b0;
        rd2Way  = '0;
        rd2Data = 32'h0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[w] && (tag_q[w] == rdAddr[ADDR_WIDTH-1 -: TAG_WIDTH])) begin
                rdHit  = 1'b1;
                rdWay  = WAY_W'(w);
                rdData = data_q[w][rdAddr[CACHE_LINE_WIDTH-1:2]];
            end else begin
                rdHit  = rdHit;
            end
            if (valid_q[w] && (tag_q[w] == rd2Addr[ADDR_WIDTH-1 -: TAG_WIDTH])) begin
                rd2Hit  = 1'b1;
                rd2Way  = WAY_W'(w);
                rd2Data = data_q[w][rd2Addr[CACHE_LINE_WIDTH-1:2]];
            end else begin
                rd2Hit  = rd2Hit;
            end
        end
    end

    // Victim: lowest-index invalid way, else follow the PLRU tree to a leaf
    always_comb begin
        int  node;
        logic found;
        node        = 0;
        found       = 1'b0;
        plru_leaf_s = '0;
        for (int l = LEVELS - 1; l >= 0; l--) begin
            plru_leaf_s[l] = plru_q[node[WAY_W-1:0]];
            node = 2 * node + 1 + int'(plru_q[node[WAY_W-1:0]]);
        end
        victimWay = plru_leaf_s;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!valid_q[w] && !found) begin
                found     = 1'b1;
                victimWay = WAY_W'(w);
            end else begin
                found     = found;
            end
        end
        victimValid = valid_q[victimWay];
        victimDirty = dirty_q[victimWay];
        victimTag   = tag_q[victimWay];
    end

    // Next line state: port write, PLRU touch, writeback dirty clear, invalidate
    always_comb begin
        int node;
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        plru_d  = plru_q;
        node    = 0;
        if (write && !busy_s) begin
            tag_d[wrWay]   = wrTag;
            valid_d[wrWay] = wrValid;
            dirty_d[wrWay] = wrDirty;
            for (int b = 0; b < 4; b++) begin
                if (wrByteEnable[b]) begin
                    data_d[wrWay][wrOff[CACHE_LINE_WIDTH-1:2]][8*b +: 8] = wrData[8*b +: 8];
                end else begin
                    data_d[wrWay][wrOff[CACHE_LINE_WIDTH-1:2]][8*b +: 8] =
                        data_q[wrWay][wrOff[CACHE_LINE_WIDTH-1:2]][8*b +: 8];
                end
            end
        end else begin
            tag_d = tag_q;
        end
        if (touch && !busy_s) begin
            // Each node on the path points away from the touched way
            for (int l = LEVELS - 1; l >= 0; l--) begin
                plru_d[node[WAY_W-1:0]] = ~touchWay[l];
                node = 2 * node + 1 + int'(touchWay[l]);
            end
        end else begin
            plru_d = plru_q;
        end
        if (wb_fire_s && last_word_s) begin
            dirty_d[way_q] = 1'b0;
        end else begin
            dirty_d = dirty_d;
        end
        if ((state_q == ST_DONE) && inv_q) begin
            valid_d = '0;
            dirty_d = '0;
        end else begin
            valid_d = valid_d;
        end
    end

    // Line state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            plru_q  <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                tag_q[w] <= '0;
                for (int i = 0; i < WORDS; i++) begin
                    data_q[w][i] <= 32'h0;
                end
            end
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            plru_q  <= plru_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    // Flush engine next-state: scan ways, stream dirty lines, optional invalidate
    always_comb begin
        state_d = state_q;
        way_d   = way_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (flushReq) begin
                    inv_d   = flushInv;
                    way_d   = '0;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (valid_q[way_q] && dirty_q[way_q]) begin
                    cnt_d   = '0;
                    state_d = ST_WB;
                end else if (last_way_s) begin
                    state_d = ST_DONE;
                end else begin
                    way_d   = way_q + 1'b1;
                end
            end
            ST_WB: begin
                if (wb_fire_s) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_word_s && last_way_s) begin
                        state_d = ST_DONE;
                    end else if (last_word_s) begin
                        way_d   = way_q + 1'b1;
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Flush engine state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            way_q   <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            way_q   <= way_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end

    // Flush outputs decode directly from registered engine state
    assign flushBusy = busy_s;
    assign flushDone = (state_q == ST_DONE);
    assign wbValid   = (state_q == ST_WB);
    assign wbWay     = way_q;
    assign wbTag     = tag_q[way_q];
    assign wbOff     = {cnt_q, 2'b00};
    assign wbData    = data_q[way_q][cnt_q];

`ifdef CACHE_SET_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Strobed hit/miss counters for lookup port 1, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else if (statStrobe && rdHit) begin
            hit_cnt_q  <= hit_cnt_q + 32'd1;
        end else if (statStrobe) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
        end else begin
            hit_cnt_q  <= hit_cnt_q;
        end
    end

    assign hitCount  = hit_cnt_q;
    assign missCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_set.sv
// Self-checking bench for cache_set (4 ways, 16-word lines).
// Writeback words are predicted into a scoreboard queue as lines are filled
// and popped when the DUT hands each word over.
module tb_cache_set;
    localparam int NW = 4;
    localparam int CLW = 6;
    localparam int TW = 20;
    localparam int AW = 32;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rdAddr, rd2Addr;
    logic          rdHit, rd2Hit;
    logic [WW-1:0] rdWay, rd2Way;
    logic [31:0]   rdData, rd2Data;
    logic          touch;
    logic [WW-1:0] touchWay;
    logic          write;
    logic [WW-1:0] wrWay;
    logic [CLW-1:0] wrOff;
    logic [TW-1:0] wrTag;
    logic          wrValid, wrDirty;
    logic [31:0]   wrData;
    logic [3:0]    wrByteEnable;
    logic [WW-1:0] victimWay;
    logic          victimValid, victimDirty;
    logic [TW-1:0] victimTag;
    logic          flushReq, flushInv, flushBusy, flushDone;
    logic          wbValid, wbReady;
    logic [WW-1:0] wbWay;
    logic [TW-1:0] wbTag;
    logic [CLW-1:0] wbOff;
    logic [31:0]   wbData;
`ifdef CACHE_SET_STATS_EN
    logic          statStrobe;
    logic [31:0]   hitCount, missCount;
`endif

    always #5 clk = ~clk;

    cache_set #(.NUM_WAYS(NW), .CACHE_LINE_WIDTH(CLW), .TAG_WIDTH(TW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rdAddr(rdAddr), .rdHit(rdHit), .rdWay(rdWay), .rdData(rdData),
        .rd2Addr(rd2Addr), .rd2Hit(rd2Hit), .rd2Way(rd2Way), .rd2Data(rd2Data),
        .touch(touch), .touchWay(touchWay),
        .write(write), .wrWay(wrWay), .wrOff(wrOff), .wrTag(wrTag),
        .wrValid(wrValid), .wrDirty(wrDirty), .wrData(wrData), .wrByteEnable(wrByteEnable),
        .victimWay(victimWay), .victimValid(victimValid), .victimDirty(victimDirty),
        .victimTag(victimTag),
        .flushReq(flushReq), .flushInv(flushInv), .flushBusy(flushBusy), .flushDone(flushDone),
        .wbValid(wbValid), .wbReady(wbReady), .wbWay(wbWay), .wbTag(wbTag),
        .wbOff(wbOff),
`ifdef CACHE_SET_STATS_EN
        .statStrobe(statStrobe), .hitCount(hitCount), .missCount(missCount),
`endif
        .wbData(wbData)
    );

    typedef struct packed {
        logic [WW-1:0]  way;
        logic [TW-1:0]  tag;
        logic [CLW-1:0] off;
        logic [31:0]    data;
    } wb_t;

    wb_t wb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_line(input logic [WW-1:0] way, input logic [CLW-1:0] off,
                              input logic [TW-1:0] tag, input logic vld, input logic drt,
                              input logic [31:0] data, input logic [3:0] be);
        write = 1'b1; wrWay = way; wrOff = off; wrTag = tag;
        wrValid = vld; wrDirty = drt; wrData = data; wrByteEnable = be;
        tick();
        write = 1'b0;
    endtask

    task automatic do_touch(input logic [WW-1:0] way);
        touch = 1'b1; touchWay = way;
        tick();
        touch = 1'b0;
    endtask

    // Fill a whole line; dirty lines that will be flushed are predicted here
    task automatic fill_line(input logic [WW-1:0] way, input logic [TW-1:0] tag,
                             input logic [31:0] base, input bit push);
        wb_t e;
        for (int i = 0; i < 16; i++) begin
            write_line(way, CLW'(i * 4), tag, 1'b1, 1'b1, base + 32'(i), 4'hF);
            if (push) begin
                e.way = way; e.tag = tag; e.off = CLW'(i * 4); e.data = base + 32'(i);
                wb_q.push_back(e);
            end
        end
    endtask

    // Start a flush and observe it cycle by cycle; k = 0 is the request cycle
    task automatic run_flush(input logic inv, input int stall_from, input int stall_len,
                             output int done_cyc, output int nvalid, output int ndone);
        logic           prev_v, prev_r;
        logic [CLW-1:0] prev_off;
        logic [31:0]    prev_data;
        wb_t            e;
        prev_v = 1'b0; prev_r = 1'b1; prev_off = '0; prev_data = 32'h0;
        done_cyc = -1; nvalid = 0; ndone = 0;
        flushReq = 1'b1; flushInv = inv;
        for (int k = 0; k < 200; k++) begin
            wbReady = !(k >= stall_from && k < stall_from + stall_len);
            @(negedge clk);
            if (wbValid) begin
                nvalid++;
                if (prev_v && !prev_r) begin
                    check_val("wb_hold_off", 64'(wbOff), 64'(prev_off));
                    check_val("wb_hold_data", 64'(wbData), 64'(prev_data));
                end
                if (wbReady && wb_q.size() == 0) begin
                    check_val("wb_extra_word", 64'(wbOff), 64'hFFFF);
                end else if (wbReady) begin
                    e = wb_q.pop_front();
                    check_val("wb_word", 64'({wbWay, wbTag, wbOff, wbData}), 64'(e));
                end else begin
                    prev_r = 1'b0;
                end
            end
            prev_v = wbValid; prev_r = wbReady; prev_off = wbOff; prev_data = wbData;
            if (flushDone) begin
                ndone++;
                if (done_cyc < 0) done_cyc = k;
            end
            tick();
            flushReq = 1'b0;
            if (done_cyc >= 0 && k > done_cyc + 2) break;
        end
        flushReq = 1'b0;
        wbReady = 1'b1;
        if (done_cyc < 0) check_val("flush_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dc, nv, nd;
        bit  seen;
        rst_n = 1'b0; rdAddr = '0; rd2Addr = '0; touch = 1'b0; touchWay = '0;
        write = 1'b0; wrWay = '0; wrOff = '0; wrTag = '0; wrValid = 1'b0; wrDirty = 1'b0;
        wrData = 32'h0; wrByteEnable = 4'h0; flushReq = 1'b0; flushInv = 1'b0; wbReady = 1'b1;
`ifdef CACHE_SET_STATS_EN
        statStrobe = 1'b0;
`endif
        #2;
        check_val("rst_busy", 64'(flushBusy), 64'd0);
        check_val("rst_wbvalid", 64'(wbValid), 64'd0);
        check_val("rst_done", 64'(flushDone), 64'd0);
        check_val("rst_hit", 64'(rdHit), 64'd0);
        check_val("rst_victim_way", 64'(victimWay), 64'd0);
        check_val("rst_victim_valid", 64'(victimValid), 64'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic write and lookup
        write_line(2'd2, 6'h08, 20'h12345, 1'b1, 1'b0, 32'hDEADBEEF, 4'hF);
        rdAddr = 32'h12345008;
        @(negedge clk);
        check_val("hit", 64'(rdHit), 64'd1);
        check_val("hit_way", 64'(rdWay), 64'd2);
        check_val("hit_data", 64'(rdData), 64'hDEADBEEF);
        check_val("victim_first_invalid", 64'(victimWay), 64'd0);
        rdAddr = 32'h12346008;
        #1;
        check_val("miss", 64'(rdHit), 64'd0);
        check_val("miss_data", 64'(rdData), 64'd0);

        // Byte-enabled write; same-cycle read returns the old word
        rdAddr = 32'h12345008;
        write = 1'b1; wrWay = 2'd2; wrOff = 6'h08; wrTag = 20'h12345; wrValid = 1'b1;
        wrDirty = 1'b0; wrData = 32'h11223344; wrByteEnable = 4'h5;
        #1;
        check_val("be_same_cycle", 64'(rdData), 64'hDEADBEEF);
        tick();
        write = 1'b0;
        check_val("be_merge", 64'(rdData), 64'hDE22BE44);

`ifdef CACHE_SET_STATS_EN
        // Three strobed hits then two strobed misses
        statStrobe = 1'b1;
        rdAddr = 32'h12345008;
        tick(); tick(); tick();
        rdAddr = 32'h0000_0000;
        tick(); tick();
        statStrobe = 1'b0;
        check_val("stat_hits", 64'(hitCount), 64'd3);
        check_val("stat_misses", 64'(missCount), 64'd2);
`endif

        // Victim selection
        write_line(2'd0, 6'h00, 20'h00010, 1'b1, 1'b0, 32'h0000_0A00, 4'hF);
        check_val("victim_after_w0", 64'(victimWay), 64'd1);
        write_line(2'd1, 6'h00, 20'h00011, 1'b1, 1'b0, 32'h0000_0B00, 4'hF);
        check_val("victim_after_w1", 64'(victimWay), 64'd3);
        write_line(2'd3, 6'h04, 20'h00013, 1'b1, 1'b0, 32'h3333_0001, 4'hF);
        rd2Addr = {20'h00013, 12'h004};
        #1;
        check_val("rd2_hit_way", 64'({rd2Hit, rd2Way}), 64'h7);
        check_val("rd2_data", 64'(rd2Data), 64'h3333_0001);
        do_touch(2'd0); do_touch(2'd1); do_touch(2'd2); do_touch(2'd3);
        check_val("plru_after_0123", 64'(victimWay), 64'd0);
        do_touch(2'd0);
        check_val("plru_after_0", 64'(victimWay), 64'd2);
        check_val("victim_tag", 64'(victimTag), 64'h12345);
        check_val("victim_valid", 64'({victimValid, victimDirty}), 64'h2);
        write_line(2'd1, 6'h00, 20'h00011, 1'b0, 1'b0, 32'h0, 4'h0);
        check_val("victim_invalid_w1", 64'(victimWay), 64'd1);
        check_val("victim_invalid_v", 64'(victimValid), 64'd0);

        // Flush with one dirty line, no backpressure
        fill_line(2'd1, 20'h00011, 32'hA500_0000, 1'b1);
        run_flush(1'b0, -1, 0, dc, nv, nd);
        check_val("f1_wbvalid_cycles", 64'(nv), 64'd16);
        check_val("f1_done_pulses", 64'(nd), 64'd1);
        check_val("f1_done_cycle", 64'(dc), 64'd21);
        check_val("f1_queue_empty", 64'(wb_q.size()), 64'd0);

        // All clean, invalidate: done exactly five cycles after the request
        run_flush(1'b1, -1, 0, dc, nv, nd);
        check_val("f2_wbvalid_cycles", 64'(nv), 64'd0);
        check_val("f2_done_cycle", 64'(dc), 64'd5);
        check_val("f2_done_pulses", 64'(nd), 64'd1);
        rdAddr = 32'h12345008;
        #1;
        check_val("f2_inv_hit", 64'(rdHit), 64'd0);
        check_val("f2_inv_victim", 64'({victimValid, victimWay}), 64'd0);

        // Backpressure in the middle of a line
        fill_line(2'd3, 20'h00013, 32'hC0DE_0000, 1'b1);
        run_flush(1'b0, 10, 3, dc, nv, nd);
        check_val("f3_wbvalid_cycles", 64'(nv), 64'd19);
        check_val("f3_done_cycle", 64'(dc), 64'd24);
        check_val("f3_queue_empty", 64'(wb_q.size()), 64'd0);

        // Reset in the middle of a writeback
        fill_line(2'd0, 20'h00077, 32'h7700_0000, 1'b0);
        wbReady = 1'b0;
        flushReq = 1'b1; flushInv = 1'b0;
        tick();
        flushReq = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = wbValid;
        end
        check_val("abort_wb_seen", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        check_val("abort_wbvalid", 64'(wbValid), 64'd0);
        check_val("abort_busy", 64'(flushBusy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wbReady = 1'b1;
        rdAddr = {20'h00077, 12'h000};
        #1;
        check_val("abort_cleared", 64'(rdHit), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
